// File: rtl/parity_pkg.sv
// Shared types and constants for the multi-lane parity frame checker.
package parity_pkg;

  // Per-lane frame position: waiting for a start bit, shifting data, awaiting parity.
  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK
  } pstate_t;

  // Parity sense as latched into each lane at its start bit.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/parity_lane.sv
// One serial lane: frames start/data/parity bits, tracks running parity,
// reports a per-frame verdict and keeps a saturating error count.
module parity_lane
  import parity_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             x_valid,
  input  logic             odd_mode,
  input  logic             clear,
  output logic             parity,
  output logic             frame_done,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count
);

  // A one-bit counter still works for DATA_BITS=1: it never leaves zero.
  localparam int               BW       = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [BW-1:0]    LAST     = BW'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  pstate_t       state;
  pstate_t       state_next;
  logic          par;
  logic          mode_q;
  logic [BW-1:0] bitcnt;

  logic take_start;
  logic take_data;
  logic take_parity;
  logic last_bit;
  logic err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state always uses <= so every register sees pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: only a qualified bit can advance the lane.
  always_comb begin
    // NOTE: defaulting first means no path leaves state_next unassigned, so no latch.
    state_next = state;
    if (x_valid) begin
      unique case (state)
        IDLE:    if (x) state_next = DATA;
        DATA:    if (last_bit) state_next = CHECK;
        CHECK:   state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Classify the bit consumed this cycle and form the frame verdict.
  always_comb begin
    take_start  = x_valid && (state == IDLE) && x;
    take_data   = x_valid && (state == DATA);
    take_parity = x_valid && (state == CHECK);
    last_bit    = (bitcnt == LAST);
    err         = ((par ^ x) != mode_q);
  end

  // Frame datapath: running parity, bit position, latched mode and result pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par        <= 1'b0;
      bitcnt     <= '0;
      mode_q     <= PAR_EVEN;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= take_parity;
      frame_err  <= take_parity && err;
      if (take_start) begin
        par    <= 1'b0;
        bitcnt <= '0;
        mode_q <= odd_mode ? PAR_ODD : PAR_EVEN;
      end
      if (take_data) begin
        par <= par ^ x;
        if (!last_bit) bitcnt <= bitcnt + 1'b1;
      end
    end
  end

  // Saturating error counter; clear takes priority over a coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else if (clear) begin
      err_count <= '0;
    end else if (take_parity && err && (err_count != CNT_MAX)) begin
      err_count <= err_count + 1'b1;
    end
  end

  // Moore parity output straight from state.
  assign parity = par;

endmodule

// File: rtl/parity_frame_checker.sv
// Multi-lane parity frame checker: CHANNELS independent lanes sharing only
// the clock, reset, parity mode and counter clear.
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int CHANNELS  = 4,
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       x,
  input  logic [CHANNELS-1:0]       x_valid,
  input  logic                      odd_mode,
  input  logic                      clear,
  output logic [CHANNELS-1:0]       parity,
  output logic [CHANNELS-1:0]       frame_done,
  output logic [CHANNELS-1:0]       frame_err,
  output logic [CHANNELS*CNT_W-1:0] err_count
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    parity_lane #(
      .DATA_BITS (DATA_BITS),
      .CNT_W     (CNT_W)
    ) u_lane (
      .clk        (clk),
      .rst        (rst),
      .x          (x[i]),
      .x_valid    (x_valid[i]),
      .odd_mode   (odd_mode),
      .clear      (clear),
      .parity     (parity[i]),
      .frame_done (frame_done[i]),
      .frame_err  (frame_err[i]),
      .err_count  (err_count[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/parity_frame_checker.md
# parity_frame_checker

- Multi-channel, parametrised successor to the single-bit Moore parity tracker.
- Each of `CHANNELS` independent serial lanes frames a start bit, `DATA_BITS` data bits and one parity bit.
- Each lane exposes its running parity as a Moore output, flags parity errors per frame (even or odd mode) and keeps a saturating error count.
- Sits behind the serial line receivers and ahead of the link-status/statistics logic.

## Interface

Parameters:
- `CHANNELS`, 4: number of independent lanes.
- `DATA_BITS`, 8: data bits per frame, excluding start and parity bits; ≥1.
- `CNT_W`, 8: width of each per-lane error counter.

Ports:
- `clk`  in  1: single clock; all logic on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `x`  in  CHANNELS: serial data bit per lane.
- `x_valid`  in  CHANNELS: lane bit qualifier; `x[i]` is consumed only when `x_valid[i]`=1.
- `odd_mode`  in  1: 0 = even parity, 1 = odd parity. Sampled per lane on its start bit.
- `clear`  in  1: synchronous clear of all error counters.
- `parity`  out  CHANNELS: running parity of data bits received so far in the current frame (Moore, from state).
- `frame_done`  out  CHANNELS: one-cycle pulse per completed frame.
- `frame_err`  out  CHANNELS: valid only with `frame_done`; 1 = parity mismatch.
- `err_count`  out  CHANNELS*CNT_W: per-lane saturating error count; lane i at bits [i*CNT_W +: CNT_W].

## Operation

- Per-lane state machine has states IDLE, DATA and CHECK, plus registers `par` (1b), `bitcnt` (enough bits to hold DATA_BITS-1) and `mode_q`.
- **IDLE:**
  - `x_valid`=1, `x`=1 is the start bit: `par`←0, `bitcnt`←0, `mode_q`←`odd_mode`, go to DATA.
  - `x_valid`=1, `x`=0 is idle line: ignored, stay in IDLE.
- **DATA:** on each valid bit, `par`←`par`^`x`.
  - If `bitcnt`==DATA_BITS-1, go to CHECK.
  - Otherwise `bitcnt`++.
- **CHECK:** the next valid bit is the parity bit `p`.
  - Compute `err` = ((`par`^`p`) != `mode_q`).
  - Register `frame_done`=1 and `frame_err`=`err`, then go to IDLE.
  - `par` holds its value until the next start bit.
- **Valid gating:** cycles with `x_valid[i]`=0 leave lane i completely unchanged.
- **Mode sampling:** `odd_mode` changes mid-frame do not affect the frame in flight.
- **Error counter:**
  - Increments on each `frame_done`&`frame_err`; saturates at 2^CNT_W-1.
  - `clear`=1 zeroes all counters. If `clear` and an increment coincide, `clear` wins and the result is 0.
- **Lane independence:** lanes share no state except `clear` and `odd_mode`.

## Timing

- **Reset values** (asynchronous, immediate): all lanes in IDLE; `parity`=0, `frame_done`=0, `frame_err`=0, `err_count`=0. `bitcnt` and `mode_q` are also 0.
- **`parity` timing:** reflects `par` and updates on the edge that consumes a data bit, so it is visible the cycle after `x_valid`.
- **Frame result latency:** `frame_done` and `frame_err` go high the cycle after the parity bit is sampled, for exactly one cycle. `frame_err` is 0 whenever `frame_done` is 0.
- **Counter latency:** `err_count` updates on the same edge that raises `frame_done`.
- **Back-to-back frames:** a start bit may be presented on the cycle immediately after the parity bit, with no idle gap required.
- **Reset mid-frame:** aborts the frame with no `frame_done`; the lane returns to IDLE.
- **Minimum frame:** with DATA_BITS=1, a frame is 3 valid bits.

## Structure

- **Shared package `parity_pkg`:**
  - state enum `pstate_t` {IDLE, DATA, CHECK};
  - mode constants `PAR_EVEN`=0, `PAR_ODD`=1.
- **Sub-module `parity_lane`:**
  - holds one lane's FSM, `par`, `bitcnt`, `mode_q`, `frame_done`/`frame_err` registers and saturating counter;
  - parametrised by DATA_BITS and CNT_W;
  - the top instantiates CHANNELS copies with a generate loop and packs outputs.

## Test plan

- **Reset defaults:** assert `rst` mid-stream → all outputs 0 immediately. Deassert, then idle zeros with valid → no state change.
- **Even-mode frames:** DATA_BITS=8, `odd_mode`=0, lane 0 sends start, 0xA5 LSB-first, parity 0 → `frame_done[0]` pulse, `frame_err`=0, `parity` ends 0. Repeat with parity bit 1 → `frame_err`=1, `err_count[0]`=1.
- **Odd mode:** `odd_mode`=1, data 0x01, parity 0 → no error. Toggle `odd_mode` mid-frame → result unchanged.
- **Gaps and back-to-back frames:** random `x_valid` gaps across two lanes with interleaved frames → per-lane results match a reference model. Back-to-back frames on one lane → two pulses.
- **Counter saturation and clear:** CNT_W=2, 5 bad frames → `err_count`=3. `clear` coincident with an error → 0.
- **Reset mid-frame:** `rst` after 4 data bits → no `frame_done`. Next full frame checks correctly.
